// File: rtl/test_pattern_generator.sv
// ---------------------------------------------------------------------------
// test_pattern_generator
//
// Multi-mode video test-pattern source. Position is tracked from the timing
// strobes and one registered 24-bit {R,G,B} value is produced per clock.
// The pattern mode is latched on end_of_frame_i only, so a frame is never
// shown with a torn pattern.
//
// Ports:
//   clk_i          pixel-domain clock
//   rst_i          asynchronous reset, active high
//   visible_i      a visible pixel is consumed this cycle
//   end_of_line_i  one-cycle strobe, restarts horizontal position
//   end_of_frame_i one-cycle strobe, restarts vertical position, latches mode
//   mode_i         requested pattern (0 bars, 1 75% bars, 2 checker,
//                  3 grey ramp, 4 solid, 5 scrolling bars, 6/7 black)
//   solid_rgb_i    colour for solid mode, sampled every cycle
//   rgb_o          registered pixel colour
// ---------------------------------------------------------------------------
module test_pattern_generator #(
    parameter int H_VISIBLE    = 640,
    parameter int V_VISIBLE    = 480,
    parameter int NUM_BARS     = 8,
    parameter int CHECKER_LOG2 = 5
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        visible_i,
    input  logic        end_of_line_i,
    input  logic        end_of_frame_i,
    input  logic [2:0]  mode_i,
    input  logic [23:0] solid_rgb_i,
    output logic [23:0] rgb_o
);

    localparam int BAR_W   = H_VISIBLE / NUM_BARS;
    localparam int XW      = (H_VISIBLE > 1) ? $clog2(H_VISIBLE) : 1;
    localparam int YW      = (V_VISIBLE > 1) ? $clog2(V_VISIBLE) : 1;
    localparam int SW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam int BW      = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;
    localparam int LOG2_NB = $clog2(NUM_BARS);
    localparam int ACC_W   = $clog2(H_VISIBLE) + 2;
    // Grey ramp step: x*256/H advances by STEP_Q whole levels plus a
    // fractional STEP_R/H per pixel, so no divider is needed at run time.
    localparam int STEP_Q  = 256 / H_VISIBLE;
    localparam int STEP_R  = 256 % H_VISIBLE;

    localparam logic [XW-1:0]    X_MAX = XW'(H_VISIBLE - 1);
    localparam logic [YW-1:0]    Y_MAX = YW'(V_VISIBLE - 1);
    localparam logic [SW-1:0]    S_MAX = SW'(BAR_W - 1);
    localparam logic [BW-1:0]    B_MAX = BW'(NUM_BARS - 1);
    localparam logic [ACC_W-1:0] H_ACC = ACC_W'(H_VISIBLE);

    logic [XW-1:0]    r_x;
    logic [YW-1:0]    r_y;
    logic [SW-1:0]    r_stripe_cnt;
    logic [BW-1:0]    r_bar_idx;
    logic [7:0]       r_frame_cnt;
    logic [2:0]       r_mode_q;
    logic [ACC_W-1:0] r_ramp_acc;
    logic [7:0]       r_ramp_g;
    logic [23:0]      r_rgb;

    logic [ACC_W-1:0] w_acc_sum;
    logic [ACC_W-1:0] w_acc_next;
    logic [7:0]       w_g_next;
    logic [BW+2:0]    w_bar_x8;
    logic [2:0]       w_bar_t;
    logic [2:0]       w_scroll_t;
    logic [XW-1:0]    w_x_sq;
    logic [YW-1:0]    w_y_sq;
    logic             w_chk_black;
    logic [23:0]      w_colour;

    function automatic logic [23:0] bar_colour(input logic [2:0] t);
        logic [23:0] c;
        case (t)
            3'd0:    c = 24'hFFFFFF;
            3'd1:    c = 24'hFFFF00;
            3'd2:    c = 24'h00FFFF;
            3'd3:    c = 24'h00FF00;
            3'd4:    c = 24'hFF00FF;
            3'd5:    c = 24'hFF0000;
            3'd6:    c = 24'h0000FF;
            default: c = 24'h000000;
        endcase
        return c;
    endfunction

    // Bar table only holds 00 and FF channels, so 75% is a per-byte swap.
    function automatic logic [23:0] scale75(input logic [23:0] c);
        logic [23:0] s;
        for (int i = 0; i < 3; i++) begin
            s[i*8 +: 8] = (c[i*8 +: 8] == 8'hFF) ? 8'hBF : c[i*8 +: 8];
        end
        return s;
    endfunction

    always_comb begin
        w_acc_sum  = r_ramp_acc + ACC_W'(STEP_R);
        w_acc_next = w_acc_sum;
        w_g_next   = r_ramp_g + 8'(STEP_Q);
        if (w_acc_sum >= H_ACC) begin
            w_acc_next = w_acc_sum - H_ACC;
            w_g_next   = r_ramp_g + 8'(STEP_Q + 1);
        end
    end

    // ---- stage 0: position counters, frame counter, mode latch ----
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_x          <= '0;
            r_y          <= '0;
            r_stripe_cnt <= '0;
            r_bar_idx    <= '0;
            r_frame_cnt  <= '0;
            r_mode_q     <= '0;
            r_ramp_acc   <= '0;
            r_ramp_g     <= '0;
        end else begin
            if (end_of_line_i || end_of_frame_i) begin
                r_x          <= '0;
                r_stripe_cnt <= '0;
                r_bar_idx    <= '0;
                r_ramp_acc   <= '0;
                r_ramp_g     <= '0;
            end else if (visible_i) begin
                // Ramp state freezes with x so overrun pixels repeat the last column.
                if (r_x != X_MAX) begin
                    r_x        <= r_x + 1'b1;
                    r_ramp_acc <= w_acc_next;
                    r_ramp_g   <= w_g_next;
                end
                if (r_stripe_cnt == S_MAX) begin
                    r_stripe_cnt <= '0;
                    if (r_bar_idx != B_MAX) begin
                        r_bar_idx <= r_bar_idx + 1'b1;
                    end
                end else begin
                    r_stripe_cnt <= r_stripe_cnt + 1'b1;
                end
            end

            if (end_of_frame_i) begin
                r_y         <= '0;
                r_frame_cnt <= r_frame_cnt + 8'd1;
                r_mode_q    <= mode_i;
            end else if (end_of_line_i && (r_y != Y_MAX)) begin
                r_y <= r_y + 1'b1;
            end
        end
    end

    always_comb begin
        // NUM_BARS is a power of two, so (bar_idx*8)/NUM_BARS is a shift.
        w_bar_x8    = {r_bar_idx, 3'b000};
        w_bar_t     = 3'(w_bar_x8 >> LOG2_NB);
        w_scroll_t  = w_bar_t + r_frame_cnt[7:5];
        w_x_sq      = r_x >> CHECKER_LOG2;
        w_y_sq      = r_y >> CHECKER_LOG2;
        w_chk_black = w_x_sq[0] ^ w_y_sq[0];
        w_colour    = 24'h000000;
        case (r_mode_q)
            3'd0:    w_colour = bar_colour(w_bar_t);
            3'd1:    w_colour = scale75(bar_colour(w_bar_t));
            3'd2:    w_colour = w_chk_black ? 24'h000000 : 24'hFFFFFF;
            3'd3:    w_colour = {r_ramp_g, r_ramp_g, r_ramp_g};
            3'd4:    w_colour = solid_rgb_i;
            3'd5:    w_colour = bar_colour(w_scroll_t);
            default: w_colour = 24'h000000;
        endcase
    end

    // ---- stage 1: registered colour from pre-update counter state ----
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rgb <= '0;
        end else begin
            r_rgb <= w_colour;
        end
    end

    assign rgb_o = r_rgb;

endmodule

// File: tb/tb_test_pattern_generator.sv
module tb_test_pattern_generator;

    localparam int H = 640;
    localparam int V = 480;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        visible_i = 1'b0;
    logic        end_of_line_i = 1'b0;
    logic        end_of_frame_i = 1'b0;
    logic [2:0]  mode_i = 3'd0;
    logic [23:0] solid_rgb_i = 24'h0;
    logic [23:0] rgb_o;
    logic [23:0] rgb4_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_k     = 0;
    int m_y     = 0;
    int m_frame = 0;
    int m_mode  = 0;

    typedef struct {
        logic [23:0] e8;
        logic [23:0] e4;
    } exp_t;
    exp_t sb[$];

    always #5 clk_i = ~clk_i;

    test_pattern_generator #(.H_VISIBLE(H), .V_VISIBLE(V), .NUM_BARS(8), .CHECKER_LOG2(5)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .visible_i(visible_i),
        .end_of_line_i(end_of_line_i), .end_of_frame_i(end_of_frame_i),
        .mode_i(mode_i), .solid_rgb_i(solid_rgb_i), .rgb_o(rgb_o));

    test_pattern_generator #(.H_VISIBLE(H), .V_VISIBLE(V), .NUM_BARS(4), .CHECKER_LOG2(5)) u_dut4 (
        .clk_i(clk_i), .rst_i(rst_i), .visible_i(visible_i),
        .end_of_line_i(end_of_line_i), .end_of_frame_i(end_of_frame_i),
        .mode_i(mode_i), .solid_rgb_i(solid_rgb_i), .rgb_o(rgb4_o));

    task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %06h expected %06h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] tbl(input int t);
        case (t & 7)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic logic [23:0] model(input int nb, input int mode, input int k,
                                          input int y, input int fc, input logic [23:0] solid);
        int x, b, t, g;
        logic [23:0] c;
        x = (k > H - 1) ? H - 1 : k;
        b = k / (H / nb);
        if (b > nb - 1) b = nb - 1;
        t = (b * 8) / nb;
        case (mode)
            0: c = tbl(t);
            1: begin
                c = tbl(t);
                for (int i = 0; i < 3; i++)
                    if (c[i*8 +: 8] == 8'hFF) c[i*8 +: 8] = 8'hBF;
            end
            2: c = ((((x >> 5) ^ (y >> 5)) & 1) == 0) ? 24'hFFFFFF : 24'h000000;
            3: begin
                g = (x * 256) / H;
                c = {g[7:0], g[7:0], g[7:0]};
            end
            4: c = solid;
            5: c = tbl(t + ((fc >> 5) & 7));
            default: c = 24'h000000;
        endcase
        return c;
    endfunction

    task automatic strobe(input logic eol, input logic eof);
        @(negedge clk_i);
        visible_i      = 1'b0;
        end_of_line_i  = eol;
        end_of_frame_i = eof;
        @(posedge clk_i);
        #1;
        if (eof) begin
            m_y     = 0;
            m_frame = (m_frame + 1) & 255;
            m_mode  = int'(mode_i);
        end else if (eol && m_y < V - 1) begin
            m_y++;
        end
        m_k = 0;
    endtask

    task automatic pixel(input string tag, output logic [23:0] obs);
        exp_t e;
        @(negedge clk_i);
        visible_i      = 1'b1;
        end_of_line_i  = 1'b0;
        end_of_frame_i = 1'b0;
        e.e8 = model(8, m_mode, m_k, m_y, m_frame, solid_rgb_i);
        e.e4 = model(4, m_mode, m_k, m_y, m_frame, solid_rgb_i);
        sb.push_back(e);
        @(posedge clk_i);
        #1;
        e = sb.pop_front();
        chk(tag, rgb_o, e.e8);
        chk({tag, "_nb4"}, rgb4_o, e.e4);
        obs = rgb_o;
        m_k++;
    endtask

    initial begin
        logic [23:0] obs;
        logic [23:0] prev;

        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_rgb", rgb_o, 24'h0);
        chk("rst_rgb_nb4", rgb4_o, 24'h0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Mode 0 default bars, with overrun pixels
        strobe(1'b1, 1'b0);
        for (int k = 0; k < H + 5; k++) begin
            pixel("m0_px", obs);
            if (k == 0)   chk("m0_bar0", obs, 24'hFFFFFF);
            if (k == 80)  chk("m0_bar1", obs, 24'hFFFF00);
            if (k == 639) chk("m0_last", obs, 24'h000000);
            if (k >= H)   chk("m0_over", obs, 24'h000000);
        end

        // Mode 1: 75% bars
        mode_i = 3'd1;
        strobe(1'b0, 1'b1);
        for (int k = 0; k < H; k++) begin
            pixel("m1_px", obs);
            if (k == 0)   chk("m1_bar0", obs, 24'hBFBFBF);
            if (k == 160) chk("m1_bar2", obs, 24'h00BFBF);
            if (k == 560) chk("m1_bar7", obs, 24'h000000);
        end

        // Mode 2: checkerboard
        mode_i = 3'd2;
        strobe(1'b0, 1'b1);
        for (int k = 0; k < 40; k++) begin
            pixel("m2_px", obs);
            if (k == 0)  chk("m2_l0_p0", obs, 24'hFFFFFF);
            if (k == 32) chk("m2_l0_p32", obs, 24'h000000);
        end
        for (int i = 0; i < 32; i++) strobe(1'b1, 1'b0);
        pixel("m2_px", obs);
        chk("m2_l32_p0", obs, 24'h000000);
        for (int i = 0; i < 8; i++) strobe(1'b1, 1'b0);
        pixel("m2_px", obs);
        // Both strobes together: frame action wins, y returns to 0
        strobe(1'b1, 1'b1);
        pixel("m2_px", obs);
        chk("both_strobes_y0", obs, 24'hFFFFFF);

        // Mode 3: grey ramp
        mode_i = 3'd3;
        strobe(1'b0, 1'b1);
        prev = 24'h0;
        for (int k = 0; k < H + 3; k++) begin
            pixel("m3_px", obs);
            if (k == 0)   chk("m3_p0", obs, 24'h000000);
            if (k == 320) chk("m3_p320", obs, 24'h808080);
            if (k == 639) chk("m3_p639", obs, 24'hFFFFFF);
            chk("m3_mono", {23'd0, (obs < prev)}, 24'd0);
            prev = obs;
        end

        // Mode-change latching: request mid-frame, applies at next frame
        mode_i = 3'd0;
        strobe(1'b0, 1'b1);
        for (int i = 0; i < 100; i++) strobe(1'b1, 1'b0);
        mode_i      = 3'd4;
        solid_rgb_i = 24'h123456;
        for (int k = 0; k < H; k++) begin
            pixel("latch_px", obs);
            if (k == 0) chk("latch_still_bars", obs, 24'hFFFFFF);
        end
        strobe(1'b1, 1'b0);
        pixel("latch_px", obs);
        strobe(1'b0, 1'b1);
        for (int k = 0; k < H; k++) begin
            pixel("m4_px", obs);
            if (k == 0 || k == 639) chk("m4_solid", obs, 24'h123456);
        end

        // Mode 5: scrolling bars after frame counter reaches 32
        mode_i = 3'd5;
        strobe(1'b0, 1'b1);
        for (int i = 0; i < 300 && m_frame != 32; i++) strobe(1'b0, 1'b1);
        for (int k = 0; k < H; k++) begin
            pixel("m5_px", obs);
            if (k == 0) chk("m5_bar0", obs, 24'hFFFF00);
        end

        // Asynchronous reset mid-line
        mode_i = 3'd0;
        strobe(1'b0, 1'b1);
        for (int k = 0; k < 10; k++) pixel("pre_rst_px", obs);
        rst_i = 1'b1;
        #1;
        chk("async_rst", rgb_o, 24'h0);
        chk("async_rst_nb4", rgb4_o, 24'h0);
        @(negedge clk_i);
        rst_i   = 1'b0;
        m_k     = 0;
        m_y     = 0;
        m_frame = 0;
        m_mode  = 0;
        for (int k = 0; k < 6; k++) begin
            pixel("post_rst_px", obs);
            if (k == 0) chk("post_rst_p0", obs, 24'hFFFFFF);
        end

        @(negedge clk_i);
        visible_i = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
